// File: rtl/regspace_apb_bridge.sv
// APB3 completer driving a register-space rreq/rack/wreq port, one word access per transfer.
// Optional wait timeout is enabled with REGSPACE_APB_TIMEOUT_EN.
module regspace_apb_bridge #(
  parameter int unsigned PADDR_W     = 18,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [PADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [ADDR_W-1:0] wreq_addr,
  output logic [DATA_W-1:0] wreq_data,
  output logic              wreq_vld,
  input  logic              wreq_rdy,
  output logic [ADDR_W-1:0] rreq_addr,
  output logic              rreq_vld,
  input  logic              rreq_rdy,
  input  logic [DATA_W-1:0] rack_data,
  input  logic              rack_vld,
  output logic              rack_rdy
);

  typedef enum logic [1:0] {StIdle, StWreq, StRreq, StDone} state_e;

  state_e state;

  // rreq_rdy is observed by the register space only; the bridge never waits on it.
  logic unused_in;

`ifdef REGSPACE_APB_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);
  logic [15:0] tmo_cnt;
  assign unused_in = rreq_rdy;
`else
  assign unused_in = rreq_rdy ^ (^TIMEOUT_CYC);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      wreq_addr <= '0;
      wreq_data <= '0;
      wreq_vld  <= 1'b0;
      rreq_addr <= '0;
      rreq_vld  <= 1'b0;
      rack_rdy  <= 1'b0;
`ifdef REGSPACE_APB_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          // Only a setup phase starts a transfer, so the access phase after DONE cannot retrigger.
          if (psel && !penable) begin
            wreq_addr <= paddr[PADDR_W-1:2];
            rreq_addr <= paddr[PADDR_W-1:2];
            wreq_data <= pwdata;
`ifdef REGSPACE_APB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
            if (paddr[1:0] != 2'b00) begin
              state   <= StDone;
              pready  <= 1'b1;
              pslverr <= 1'b1;
            end else if (pwrite) begin
              state    <= StWreq;
              wreq_vld <= 1'b1;
            end else begin
              state    <= StRreq;
              rreq_vld <= 1'b1;
              rack_rdy <= 1'b1;
            end
          end
        end
        StWreq: begin
          if (wreq_rdy) begin
            state    <= StDone;
            wreq_vld <= 1'b0;
            pready   <= 1'b1;
            pslverr  <= 1'b0;
          end
`ifdef REGSPACE_APB_TIMEOUT_EN
          else if (tmo_cnt == TimeoutLast) begin
            state    <= StDone;
            wreq_vld <= 1'b0;
            pready   <= 1'b1;
            pslverr  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end
        StRreq: begin
          if (rack_vld) begin
            state    <= StDone;
            prdata   <= rack_data;
            rreq_vld <= 1'b0;
            rack_rdy <= 1'b0;
            pready   <= 1'b1;
            pslverr  <= 1'b0;
          end
`ifdef REGSPACE_APB_TIMEOUT_EN
          else if (tmo_cnt == TimeoutLast) begin
            state    <= StDone;
            prdata   <= '0;
            rreq_vld <= 1'b0;
            rack_rdy <= 1'b0;
            pready   <= 1'b1;
            pslverr  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end
        StDone: begin
          state   <= StIdle;
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_regspace_apb_bridge.sv
// Scoreboard bench for regspace_apb_bridge: stimulus pushes expected completions and write
// requests, a negedge monitor pops and compares whenever the DUT presents them.
module tb_regspace_apb_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [17:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [15:0] wreq_addr, rreq_addr;
  logic [31:0] wreq_data;
  logic        wreq_vld, wreq_rdy, rreq_vld, rreq_rdy, rack_vld, rack_rdy;
  logic [31:0] rack_data;

  always #5 clk = ~clk;

  regspace_apb_bridge #(
    .PADDR_W(18), .ADDR_W(16), .DATA_W(32), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .wreq_addr(wreq_addr), .wreq_data(wreq_data), .wreq_vld(wreq_vld), .wreq_rdy(wreq_rdy),
    .rreq_addr(rreq_addr), .rreq_vld(rreq_vld), .rreq_rdy(rreq_rdy),
    .rack_data(rack_data), .rack_vld(rack_vld), .rack_rdy(rack_rdy)
  );

  typedef struct packed { logic [31:0] rd; logic err; } cpl_t;
  typedef struct packed { logic [15:0] addr; logic [31:0] data; } wr_t;

  cpl_t        cpl_q[$];
  wr_t         wr_q[$];
  logic [15:0] exp_raddr;
  int          n_tests = 0;
  int          n_fail = 0;
  int          rack_delay = 0;
  int          rcnt = 0;
  int          rrun = 0;
  int          last_rrun = 0;
  int          wcyc = 0;
  logic        prev_pready = 1'b0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Register-space read responder: rack_vld rises after rack_delay RREQ cycles.
  initial begin
    rack_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (rreq_vld) begin
        rcnt++;
        rack_vld = (rcnt > rack_delay);
      end else begin
        rcnt = 0;
        rack_vld = 1'b0;
      end
    end
  end

  // Monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pready) begin
        if (cpl_q.size() == 0) begin
          check("unexpected_pready", 32'(pready), 32'd0);
        end else begin
          cpl_t e;
          e = cpl_q.pop_front();
          check("prdata", prdata, e.rd);
          check("pslverr", 32'(pslverr), 32'(e.err));
        end
      end
      if (prev_pready) begin
        check("prdata_cleared", prdata, 32'd0);
        check("pready_one_cycle", 32'(pready), 32'd0);
      end
      prev_pready = pready;
      if (wreq_vld) begin
        wcyc++;
        check("no_dual_vld", 32'(rreq_vld), 32'd0);
        if (wreq_rdy) begin
          if (wr_q.size() == 0) begin
            check("unexpected_wreq", 32'(wreq_vld), 32'd0);
          end else begin
            wr_t w;
            w = wr_q.pop_front();
            check("wreq_addr", 32'(wreq_addr), 32'(w.addr));
            check("wreq_data", wreq_data, w.data);
          end
        end
      end
      if (rreq_vld) begin
        rrun++;
        check("rreq_addr", 32'(rreq_addr), 32'(exp_raddr));
        check("rack_rdy", 32'(rack_rdy), 32'd1);
      end else if (rrun != 0) begin
        last_rrun = rrun;
        rrun = 0;
      end
    end else begin
      prev_pready = 1'b0;
      rrun = 0;
    end
  end

  task automatic apb_xfer(input logic wr, input logic [17:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                          input string nm);
    int  lat;
    bit  done;
    cpl_t c;
    wr_t  w;
    c.rd = exp_rd;
    c.err = exp_err;
    cpl_q.push_back(c);
    if (addr[1:0] == 2'b00) begin
      if (wr) begin
        w.addr = addr[17:2];
        w.data = wd;
        wr_q.push_back(w);
      end else begin
        exp_raddr = addr[17:2];
      end
    end
    @(posedge clk);
    #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clk);
    #1;
    penable = 1'b1;
    lat = 1;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (pready) done = 1;
      else if (lat >= 300) begin
        check({nm, "_timeout"}, 32'(lat), 32'(exp_lat));
        done = 1;
      end else lat++;
    end
    check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    int w0;
    rst_n = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    wreq_rdy = 1'b1; rreq_rdy = 1'b1; rack_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check("rst_wreq_vld", 32'(wreq_vld), 32'd0);
    check("rst_rreq_vld", 32'(rreq_vld), 32'd0);
    check("rst_rack_rdy", 32'(rack_rdy), 32'd0);
    check("rst_wreq_addr", 32'(wreq_addr), 32'd0);
    rst_n = 1'b1;

    // Zero-wait write.
    w0 = wcyc;
    apb_xfer(1'b1, 18'h00004, 32'hDEADBEEF, 32'h0, 1'b0, 2, "wr4");
    check("wr4_vld_cycles", 32'(wcyc - w0), 32'd1);

    // Zero-wait read.
    rack_delay = 0; rack_data = 32'hA5A5_0001;
    apb_xfer(1'b0, 18'h00000, 32'h1234_5678, 32'hA5A5_0001, 1'b0, 2, "rd0");
    check("rd0_rreq_cycles", 32'(last_rrun), 32'd1);

    // Read with five wait cycles on the register space.
    rack_delay = 5; rack_data = 32'h0BAD_F00D;
    apb_xfer(1'b0, 18'h00010, 32'h0, 32'h0BAD_F00D, 1'b0, 7, "rd_slow");
    check("rd_slow_rreq_cycles", 32'(last_rrun), 32'd6);

    // Misaligned write and read: no request, error at T1.
    w0 = wcyc;
    apb_xfer(1'b1, 18'h00006, 32'hCAFE_CAFE, 32'h0, 1'b1, 1, "mis_wr");
    check("mis_wr_no_wreq", 32'(wcyc - w0), 32'd0);
    rack_delay = 0; rack_data = 32'hFFFF_FFFF;
    apb_xfer(1'b0, 18'h00003, 32'h0, 32'h0, 1'b1, 1, "mis_rd");

    // Highest word address.
    apb_xfer(1'b1, 18'h3FFFC, 32'h0123_4567, 32'h0, 1'b0, 2, "wr_top");

`ifdef REGSPACE_APB_TIMEOUT_EN
    rack_delay = 1000;
    apb_xfer(1'b0, 18'h00020, 32'h0, 32'h0, 1'b1, 9, "rd_tmo");
    check("rd_tmo_rreq_cycles", 32'(last_rrun), 32'd8);
    apb_xfer(1'b1, 18'h00024, 32'h5555_AAAA, 32'h0, 1'b0, 2, "wr_after_tmo");
`endif

    // Reset in the middle of a stalled read aborts with no completion.
    rack_delay = 1000;
    exp_raddr = 16'h0002;
    @(posedge clk);
    #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 18'h00008;
    @(posedge clk);
    #1;
    penable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_rreq_vld", 32'(rreq_vld), 32'd0);
    check("abort_rack_rdy", 32'(rack_rdy), 32'd0);
    check("abort_pready", 32'(pready), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    rack_delay = 1; rack_data = 32'h7777_1234;
    apb_xfer(1'b0, 18'h0000C, 32'h0, 32'h7777_1234, 1'b0, 3, "rd_after_rst");
    apb_xfer(1'b1, 18'h00008, 32'h8888_0000, 32'h0, 1'b0, 2, "wr_after_rst");

    repeat (3) @(posedge clk);
    check("cpl_queue_drained", 32'(cpl_q.size()), 32'd0);
    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
